io_port_responder: RTL
======================

Name: io_port_responder

Overview:
- External-side peripheral that sits on the processor's 8-bit bidirectional IO pins; the other end of the CPU I/O port.
- When the CPU drives the port, it captures distinct values into an RX FIFO that a host/testbench pops.
- When the CPU reads the port, it drives a host-loaded TX value onto IO.
- Bus turnaround cycles guarantee both ends never drive simultaneously.

Parameters:
WIDTH, 8, IO/data width in bits
DEPTH, 4, RX FIFO entries (power of 2, >=2)
TURN_CYCLES, 1, dead cycles on every direction change (>=1)

Ports:
CLK  input  1  clock, all flops rising-edge
RST  input  1  asynchronous active-high reset
IO  inout  WIDTH  CPU port pins; driven only in DRIVE state, else high-Z
DIR  input  1  port direction from CPU side: 1 = CPU drives IO, 0 = CPU reads IO
TX_DATA  input  WIDTH  value to present to the CPU
TX_WR  input  1  load TX_DATA into TX register
RX_DATA  output  WIDTH  FIFO head; valid when RX_VALID
RX_VALID  output  1  FIFO not empty
RX_RD  input  1  pop head; ignored when empty
RX_COUNT  output  clog2(DEPTH)+1  entries held
RX_OVF  output  1  sticky overflow flag
DRIVING  output  1  high exactly while IO is driven

Behaviour:
- Reset (async): state=LISTEN, first-sample flag=1, LAST=0, TX register=0, FIFO empty, RX_COUNT=0, RX_VALID=0, RX_DATA=0, RX_OVF=0, DRIVING=0, IO high-Z. Reset mid-transfer discards FIFO contents and releases IO immediately.
- DIR registered once into DIR_Q; all transitions use DIR_Q.
- States: LISTEN, TURN_ON, DRIVE, TURN_OFF; turnaround counter loads TURN_CYCLES on entry to TURN_ON/TURN_OFF.
  - LISTEN: DIR_Q=0 -> TURN_ON.
  - TURN_ON: counter decrements; DIR_Q=1 -> TURN_OFF (abort); counter hits 0 -> DRIVE.
  - DRIVE: DIR_Q=1 -> TURN_OFF.
  - TURN_OFF: counter decrements; DIR_Q=0 -> TURN_ON; counter hits 0 -> LISTEN with first-sample flag set.
- IO=TX register and DRIVING=1 only in DRIVE (decoded from registered state); high-Z otherwise.
- TX_WR loads at edge; new value visible on IO the cycle after, if in DRIVE. TX register is retained across direction changes.
- Capture: in LISTEN each edge samples IO. Push when the sample differs from LAST, or the first-sample flag is set. Flag clears after the first sample; LAST updates on every sample.
- No sampling in TURN_ON/DRIVE/TURN_OFF.
- FIFO: circular, pointer wrap at DEPTH. Push when full drops the sample and sets RX_OVF. RX_OVF clears only by reset.
- Simultaneous push+pop:
  - Not empty and not full: count unchanged.
  - Full: pop frees a slot, push accepted, no overflow.
  - Empty: push only; pop ignored.
- RX_DATA updates the cycle after a pop/push (registered head read).

Optional Feature:
- Macro IO_DIR_SYNC_EN.
- Defined: DIR passes through a two-flop synchronizer before DIR_Q, adding 2 cycles to every transition latency.
- Undefined: single register stage as above.

Test Plan:
- Reset, DIR=1, IO driven 0x5A for 3 cycles, then 0x5A again -> exactly one push (0x5A); RX_COUNT=1; RX_VALID=1; DRIVING=0.
- DIR=1, IO sequence 0x01,0x02,0x03,0x04,0x05 with no pops -> four entries 01..04, 0x05 dropped, RX_OVF=1 sticky; pop all -> RX_DATA 01,02,03,04, RX_COUNT=0, RX_OVF still 1.
- TX_WR with 0xC3, then DIR 1->0 -> IO high-Z through DIR_Q edge + TURN_CYCLES, then IO=0xC3, DRIVING=1; TX_WR 0x3C in DRIVE -> IO=0x3C next cycle.
- In DRIVE, DIR 0->1 -> IO high-Z on the next registered state, TURN_CYCLES blanking, back in LISTEN. First sample pushed even if equal to the pre-switch LAST value (e.g. 0x5A).
- FIFO full with push and RX_RD in the same cycle -> RX_COUNT stays 4, new value queued at tail, RX_OVF stays 0.
- Assert RST mid-DRIVE with FIFO at 3 entries -> IO high-Z and RX_COUNT=0 asynchronously. With IO_DIR_SYNC_EN defined, DIR change to DRIVING=1 latency increases by 2 cycles.

Source files
------------

// File: rtl/io_port_responder.sv
// -----------------------------------------------------------------------------
// io_port_responder
//
// This block is the external-side peer of a CPU's 8-bit bidirectional I/O
// port. It sits on the same pins as the CPU.
//   * When the CPU drives the pins (DIR=1), the block samples them while
//     listening. It queues every value that differs from the previous sample
//     into an RX FIFO, which the host pops.
//   * When the CPU reads the pins (DIR=0), the block drives a host-loaded TX
//     value onto them.
//   * Every change of direction passes through TURN_CYCLES dead cycles. During
//     those cycles neither side drives, so the two ends never fight.
//
// Optional build macro:
//   IO_DIR_SYNC_EN - when defined, DIR passes through a two-flop synchronizer
//                    before the direction register. This adds two cycles to
//                    every direction-change latency. When undefined, DIR is
//                    registered once.
//
// Ports:
//   CLK       in   clock, all flops rising-edge
//   RST       in   asynchronous active-high reset
//   IO        io   CPU port pins; driven only in DRIVE, high-Z otherwise
//   DIR       in   1 = CPU drives IO, 0 = CPU reads IO
//   TX_DATA   in   value to present to the CPU
//   TX_WR     in   load TX_DATA into the TX register
//   RX_DATA   out  registered FIFO head, valid when RX_VALID
//   RX_VALID  out  FIFO not empty
//   RX_RD     in   pop the FIFO head (ignored when empty)
//   RX_COUNT  out  number of entries held
//   RX_OVF    out  sticky overflow flag, cleared only by reset
//   DRIVING   out  high exactly while IO is driven
// -----------------------------------------------------------------------------
module io_port_responder #(
  parameter int WIDTH       = 8,
  parameter int DEPTH       = 4,
  parameter int TURN_CYCLES = 1
) (
  input  logic                     CLK,
  input  logic                     RST,
  inout  wire  [WIDTH-1:0]         IO,
  input  logic                     DIR,
  input  logic [WIDTH-1:0]         TX_DATA,
  input  logic                     TX_WR,
  output logic [WIDTH-1:0]         RX_DATA,
  output logic                     RX_VALID,
  input  logic                     RX_RD,
  output logic [$clog2(DEPTH):0]   RX_COUNT,
  output logic                     RX_OVF,
  output logic                     DRIVING
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam int TC_W  = $clog2(TURN_CYCLES + 1);

  localparam logic [TC_W-1:0]  TC_LOAD   = TC_W'(TURN_CYCLES);
  localparam logic [CNT_W-1:0] CNT_FULL  = CNT_W'(DEPTH);

  typedef enum logic [1:0] {
    LISTEN   = 2'd0,
    TURN_ON  = 2'd1,
    DRIVE    = 2'd2,
    TURN_OFF = 2'd3
  } state_t;

  // ---------------------------------------------------------------------------
  // Direction register (optionally behind a two-flop synchronizer).
  // All direction registers reset to 1. This matches the LISTEN reset state,
  // so the block does not start a turnaround straight out of reset.
  // ---------------------------------------------------------------------------
  logic dir_q;

`ifdef IO_DIR_SYNC_EN
  logic dir_s1_q;
  logic dir_s2_q;

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      dir_s1_q <= 1'b1;
      dir_s2_q <= 1'b1;
      dir_q    <= 1'b1;
    end else begin
      dir_s1_q <= DIR;
      dir_s2_q <= dir_s1_q;
      dir_q    <= dir_s2_q;
    end
  end
`else
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      dir_q <= 1'b1;
    end else begin
      dir_q <= DIR;
    end
  end
`endif

  // ---------------------------------------------------------------------------
  // Port direction FSM
  // ---------------------------------------------------------------------------
  state_t            state_q, state_d;
  logic [TC_W-1:0]   tc_q, tc_d;
  logic [TC_W-1:0]   tc_dec;
  logic              first_set;

  assign tc_dec = tc_q - TC_W'(1);

  // NOTE: every variable assigned in this always_comb gets a default first.
  // A branch that skips a default would otherwise infer a latch.
  always_comb begin
    state_d   = state_q;
    tc_d      = tc_q;
    first_set = 1'b0;
    unique case (state_q)
      LISTEN: begin
        if (!dir_q) begin
          state_d = TURN_ON;
          tc_d    = TC_LOAD;
        end
      end
      TURN_ON: begin
        tc_d = tc_dec;
        if (dir_q) begin
          // The CPU changed its mind mid-turnaround: head back to listening.
          state_d = TURN_OFF;
          tc_d    = TC_LOAD;
        end else if (tc_dec == '0) begin
          state_d = DRIVE;
        end
      end
      DRIVE: begin
        if (dir_q) begin
          state_d = TURN_OFF;
          tc_d    = TC_LOAD;
        end
      end
      TURN_OFF: begin
        tc_d = tc_dec;
        if (!dir_q) begin
          state_d = TURN_ON;
          tc_d    = TC_LOAD;
        end else if (tc_dec == '0) begin
          // Re-entering LISTEN always captures the first sample, even when it
          // equals the value seen before the bus was turned around.
          state_d   = LISTEN;
          first_set = 1'b1;
        end
      end
      default: begin
        state_d = LISTEN;
      end
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments only. This keeps
  // every flop sampling the pre-edge value of every other flop.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q <= LISTEN;
      tc_q    <= '0;
    end else begin
      state_q <= state_d;
      tc_q    <= tc_d;
    end
  end

  // ---------------------------------------------------------------------------
  // TX register and pin drive (decoded from registered state only)
  // ---------------------------------------------------------------------------
  logic [WIDTH-1:0] tx_q, tx_d;
  logic             drive_en;

  assign tx_d     = TX_WR ? TX_DATA : tx_q;
  assign drive_en = (state_q == DRIVE);
  assign IO       = drive_en ? tx_q : {WIDTH{1'bz}};
  assign DRIVING  = drive_en;

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      tx_q <= '0;
    end else begin
      tx_q <= tx_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Capture: sample IO every edge spent in LISTEN. Push on change, or
  // unconditionally on the first sample after reset or a turnaround.
  // ---------------------------------------------------------------------------
  logic [WIDTH-1:0] last_q, last_d;
  logic             first_q, first_d;
  logic             sampling;
  logic             push_req;

  assign sampling = (state_q == LISTEN);
  assign push_req = sampling && (first_q || (IO != last_q));
  assign last_d   = sampling ? IO : last_q;

  always_comb begin
    first_d = first_q;
    if (first_set) begin
      first_d = 1'b1;
    end else if (sampling) begin
      first_d = 1'b0;
    end
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      last_q  <= '0;
      first_q <= 1'b1;
    end else begin
      last_q  <= last_d;
      first_q <= first_d;
    end
  end

  // ---------------------------------------------------------------------------
  // RX FIFO: circular buffer with pointers that wrap naturally at DEPTH
  // (DEPTH is a power of two).
  // ---------------------------------------------------------------------------
  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic [WIDTH-1:0] rx_data_q, rx_data_d;
  logic             ovf_q, ovf_d;
  logic             full, empty;
  logic             pop_ok, push_ok;
  logic [WIDTH-1:0] head_next;

  assign full  = (count_q == CNT_FULL);
  assign empty = (count_q == '0);

  // A pop on a full FIFO frees the slot that the same-cycle push then uses.
  assign pop_ok  = RX_RD && !empty;
  assign push_ok = push_req && (!full || pop_ok);
  assign ovf_d   = ovf_q || (push_req && full && !pop_ok);

  assign wr_ptr_d = push_ok ? wr_ptr_q + PTR_W'(1) : wr_ptr_q;
  assign rd_ptr_d = pop_ok  ? rd_ptr_q + PTR_W'(1) : rd_ptr_q;

  always_comb begin
    count_d = count_q;
    unique case ({push_ok, pop_ok})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase
  end

  // The head after this edge is either an already stored entry, or the value
  // being pushed right now. The second case is a bypass: the new value lands
  // exactly in the slot the read pointer moves to (empty FIFO, or one entry
  // popped while one is pushed).
  assign head_next = (push_ok && (rd_ptr_d == wr_ptr_q)) ? IO : mem_q[rd_ptr_d];
  assign rx_data_d = (count_d != '0) ? head_next : rx_data_q;

  // NOTE: the storage array is not reset. The count and pointers define which
  // entries are valid, so stale contents are never observed.
  always_ff @(posedge CLK) begin
    if (push_ok) begin
      mem_q[wr_ptr_q] <= IO;
    end
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      count_q   <= '0;
      rx_data_q <= '0;
      ovf_q     <= 1'b0;
    end else begin
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      count_q   <= count_d;
      rx_data_q <= rx_data_d;
      ovf_q     <= ovf_d;
    end
  end

  assign RX_DATA  = rx_data_q;
  assign RX_VALID = !empty;
  assign RX_COUNT = count_q;
  assign RX_OVF   = ovf_q;

endmodule
